// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard timing presets, a clog2 helper and the packed pixel type.
package vga_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    localparam int PIX_COLOR_W = 2;

    typedef struct packed {
        logic [PIX_COLOR_W-1:0] r;
        logic [PIX_COLOR_W-1:0] g;
        logic [PIX_COLOR_W-1:0] b;
    } pixel_t;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 32'sd31; i++) begin
            if ((32'sd1 <<< i) < value) result = i + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_scaled_controller_if.sv
// Framebuffer read port: the scaled VGA controller is the master, the pixel RAM the slave.
interface vga_scaled_controller_if #(
    parameter int COLOR_W = 2,
    parameter int ADDR_W  = 17
) ();
    logic                 fb_ready;
    logic [3*COLOR_W-1:0] din;
    logic [ADDR_W-1:0]    addr;

    modport master (input fb_ready, input din, output addr);
    modport slave  (output fb_ready, output din, input addr);
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA counters plus stage-0 registered sync, active, window and frame flags.
// With VGA_TEST_PATTERN_EN defined it also registers the colour-bar index.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_W    = 640,
    parameter int WIN_H    = 480
) (
    input  logic       vga_clk_25,
    input  logic       reset,
    input  logic       fb_ready,
    output logic       advance,
    output logic       win,
    output logic       line_end,
    output logic       frame_end,
    output logic       hsync_s0,
    output logic       vsync_s0,
    output logic       active_s0,
    output logic       win_s0,
    output logic       frame_s0
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [2:0] bar_s0
`endif
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_W    = clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             started_r;
    logic [CNT_W-1:0] h_count_r;
    logic [CNT_W-1:0] v_count_r;
    logic [31:0]      h_ext_s;
    logic [31:0]      v_ext_s;

    assign h_ext_s   = 32'(h_count_r);
    assign v_ext_s   = 32'(v_count_r);
    // Before start the counters sit at 0 until fb_ready is first seen; afterwards they free-run.
    assign advance   = started_r | fb_ready;
    assign line_end  = (h_count_r == H_LAST);
    assign frame_end = line_end && (v_count_r == V_LAST);
    assign win       = (h_ext_s < WIN_W) && (v_ext_s < WIN_H);

    // Start latch, pixel/line counters and the stage-0 flag registers.
    always_ff @(posedge vga_clk_25) begin
        if (reset) begin
            started_r <= 1'b0;
            h_count_r <= CNT_ZERO;
            v_count_r <= CNT_ZERO;
            hsync_s0  <= 1'b0;
            vsync_s0  <= 1'b0;
            active_s0 <= 1'b0;
            win_s0    <= 1'b0;
            frame_s0  <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            bar_s0    <= 3'b000;
`endif
        end else if (advance) begin
            started_r <= 1'b1;
            hsync_s0  <= (h_ext_s >= HS_START) && (h_ext_s < HS_END);
            vsync_s0  <= (v_ext_s >= VS_START) && (v_ext_s < VS_END);
            active_s0 <= (h_ext_s < H_ACTIVE) && (v_ext_s < V_ACTIVE);
            win_s0    <= win;
            frame_s0  <= (h_count_r == CNT_ZERO) && (v_count_r == CNT_ZERO);
`ifdef VGA_TEST_PATTERN_EN
            bar_s0    <= 3'(h_ext_s / ((H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1));
`endif
            if (line_end) begin
                h_count_r <= CNT_ZERO;
                v_count_r <= frame_end ? CNT_ZERO : (v_count_r + CNT_ONE);
            end else begin
                h_count_r <= h_count_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/vga_scaled_controller.sv
// Scaled VGA controller: framebuffer addressing, read-latency alignment and colour output.
// Define VGA_TEST_PATTERN_EN to add the test_pattern input and its colour-bar override.
module vga_scaled_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int SCALE      = 2,
    parameter int COLOR_W    = 2,
    parameter int ADDR_W     = 17,
    parameter int RD_LATENCY = 1
) (
    input  logic                   vga_clk_25,
    input  logic                   reset,
    vga_scaled_controller_if.master fb,
    input  logic [3*COLOR_W-1:0]   border_colour,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   test_pattern,
`endif
    output logic                   hsync,
    output logic                   vsync,
    output logic [COLOR_W-1:0]     R,
    output logic [COLOR_W-1:0]     G,
    output logic [COLOR_W-1:0]     B,
    output logic                   frame_start
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int F_HS  = 0;
    localparam int F_VS  = 1;
    localparam int F_ACT = 2;
    localparam int F_WIN = 3;
    localparam int F_FRM = 4;
`ifdef VGA_TEST_PATTERN_EN
    localparam int F_BAR  = 5;
    localparam int FLAG_W = 8;
`else
    localparam int FLAG_W = 5;
`endif

    localparam logic              HS_ON    = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic              VS_ON    = (VSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [1:0]        SUB_LAST = 2'(SCALE - 1);
    localparam logic [1:0]        SUB_ONE  = 2'b01;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

    logic              advance_s, win_s, line_end_s, frame_end_s;
    logic              hsync_s0_s, vsync_s0_s, active_s0_s, win_s0_s, frame_s0_s;
    logic [ADDR_W-1:0] addr_r, col_r, line_base_r;
    logic [1:0]        x_sub_r, y_sub_r;
    logic [FLAG_W-1:0] stage0_s, tap_s;
    logic [FLAG_W-1:0] dly_r [RD_LATENCY];
    logic [PIX_W-1:0]  pix_s;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]        bar_s0_s;
    logic [PIX_W-1:0]  bar_pix_s;
`endif

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .WIN_W(FB_WIDTH * SCALE), .WIN_H(FB_HEIGHT * SCALE)
    ) u_timing (
        .vga_clk_25 (vga_clk_25),
        .reset      (reset),
        .fb_ready   (fb.fb_ready),
        .advance    (advance_s),
        .win        (win_s),
        .line_end   (line_end_s),
        .frame_end  (frame_end_s),
        .hsync_s0   (hsync_s0_s),
        .vsync_s0   (vsync_s0_s),
        .active_s0  (active_s0_s),
        .win_s0     (win_s0_s),
        .frame_s0   (frame_s0_s)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .bar_s0     (bar_s0_s)
`endif
    );

    assign fb.addr = addr_r;

    // Incremental addressing: each column repeats SCALE pixels, each row SCALE lines.
    always_ff @(posedge vga_clk_25) begin
        if (reset) begin
            addr_r      <= {ADDR_W{1'b0}};
            col_r       <= {ADDR_W{1'b0}};
            line_base_r <= {ADDR_W{1'b0}};
            x_sub_r     <= 2'b00;
            y_sub_r     <= 2'b00;
        end else if (advance_s) begin
            if (win_s) begin
                addr_r <= line_base_r + col_r;
                if (x_sub_r == SUB_LAST) begin
                    x_sub_r <= 2'b00;
                    col_r   <= col_r + ADDR_ONE;
                end else begin
                    x_sub_r <= x_sub_r + SUB_ONE;
                end
            end
            if (line_end_s) begin
                x_sub_r <= 2'b00;
                col_r   <= {ADDR_W{1'b0}};
                if (frame_end_s) begin
                    y_sub_r     <= 2'b00;
                    line_base_r <= {ADDR_W{1'b0}};
                end else if (y_sub_r == SUB_LAST) begin
                    y_sub_r     <= 2'b00;
                    line_base_r <= line_base_r + ROW_STEP;
                end else begin
                    y_sub_r <= y_sub_r + SUB_ONE;
                end
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign stage0_s  = {bar_s0_s, frame_s0_s, win_s0_s, active_s0_s, vsync_s0_s, hsync_s0_s};
    assign bar_pix_s = {{COLOR_W{tap_s[F_BAR+2]}}, {COLOR_W{tap_s[F_BAR+1]}}, {COLOR_W{tap_s[F_BAR]}}};
`else
    assign stage0_s  = {frame_s0_s, win_s0_s, active_s0_s, vsync_s0_s, hsync_s0_s};
`endif
    assign tap_s = dly_r[RD_LATENCY-1];

    // Delay line keeping sync and flags aligned with the framebuffer read data.
    always_ff @(posedge vga_clk_25) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) dly_r[i] <= {FLAG_W{1'b0}};
        end else begin
            dly_r[0] <= stage0_s;
            for (int i = 1; i < RD_LATENCY; i++) dly_r[i] <= dly_r[i-1];
        end
    end

    // Colour select: window pixels come from the framebuffer, the rest of the active area is border.
    always_comb begin
        pix_s = {PIX_W{1'b0}};
        if (!tap_s[F_ACT]) begin
            pix_s = {PIX_W{1'b0}};
`ifdef VGA_TEST_PATTERN_EN
        end else if (test_pattern) begin
            pix_s = bar_pix_s;
`endif
        end else if (tap_s[F_WIN]) begin
            pix_s = fb.din;
        end else begin
            pix_s = border_colour;
        end
    end

    // Registered pin stage.
    always_ff @(posedge vga_clk_25) begin
        if (reset) begin
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            R           <= {COLOR_W{1'b0}};
            G           <= {COLOR_W{1'b0}};
            B           <= {COLOR_W{1'b0}};
            frame_start <= 1'b0;
        end else begin
            hsync       <= tap_s[F_HS] ? HS_ON : ~HS_ON;
            vsync       <= tap_s[F_VS] ? VS_ON : ~VS_ON;
            {R, G, B}   <= pix_s;
            frame_start <= tap_s[F_FRM];
        end
    end

endmodule

// File: tb/tb_vga_scaled_controller.sv
// Bench for vga_scaled_controller: three small-mode instances (scale, latency, polarity, clipping)
// checked every cycle against a pixel-position reference model.
module tb_vga_scaled_controller;
    localparam int NDUT = 3;
    localparam int HA = 32, HF = 4, HS = 6, HB = 6;
    localparam int VA = 24, VF = 2, VS = 3, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int SC   [NDUT] = '{2, 3, 1};
    localparam int FBW  [NDUT] = '{12, 12, 20};
    localparam int FBH  [NDUT] = '{10, 9, 16};
    localparam int LAT  [NDUT] = '{1, 3, 2};
    localparam int HPOL [NDUT] = '{0, 1, 0};
    localparam int VPOL [NDUT] = '{0, 1, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic        fb_ready;
    logic [5:0]  border;
    logic [5:0]  salt;
    logic        hs_o   [NDUT];
    logic        vs_o   [NDUT];
    logic        fs_o   [NDUT];
    logic [1:0]  r_o    [NDUT];
    logic [1:0]  g_o    [NDUT];
    logic [1:0]  b_o    [NDUT];
    logic [16:0] addr_o [NDUT];

    int n_vec = 0;
    int n_err = 0;
    int n = -1;
    bit running = 1'b0;
    int m_addr [NDUT];

    always #5 clk = ~clk;

    // Framebuffer contents: a fixed scramble of the address.
    function automatic logic [5:0] ram_word(input logic [16:0] a, input logic [5:0] s);
        return a[5:0] ^ a[11:6] ^ s;
    endfunction

    for (genvar d = 0; d < NDUT; d++) begin : g_dut
        logic [16:0] rp [3];
        vga_scaled_controller_if #(.COLOR_W(2), .ADDR_W(17)) fb ();

        assign fb.fb_ready = fb_ready;
        assign fb.din      = ram_word(rp[LAT[d]-1], salt);
        assign addr_o[d]   = fb.addr;

        // RAM read pipeline of depth RD_LATENCY.
        always @(posedge clk) begin
            rp[0] <= fb.addr;
            rp[1] <= rp[0];
            rp[2] <= rp[1];
        end

        vga_scaled_controller #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .HSYNC_POL(HPOL[d]), .VSYNC_POL(VPOL[d]),
            .FB_WIDTH(FBW[d]), .FB_HEIGHT(FBH[d]), .SCALE(SC[d]),
            .COLOR_W(2), .ADDR_W(17), .RD_LATENCY(LAT[d])
        ) dut (
            .vga_clk_25    (clk),
            .reset         (reset),
            .fb            (fb),
            .border_colour (border),
`ifdef VGA_TEST_PATTERN_EN
            .test_pattern  (1'b0),
`endif
            .hsync         (hs_o[d]),
            .vsync         (vs_o[d]),
            .R             (r_o[d]),
            .G             (g_o[d]),
            .B             (b_o[d]),
            .frame_start   (fs_o[d])
        );
    end

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d n=%0d: observed %0h expected %0h", tag, d, n, obs, exp);
        end
    endtask

    // Reference: pixel n is at stage 0 now, and pixel n-LAT-1 is on the pins.
    task automatic check_cycle();
        for (int d = 0; d < NDUT; d++) begin
            int  m, h, v;
            logic ehs, evs, efs, hp, vp;
            logic [5:0] epix;
            hp = (HPOL[d] != 0);
            vp = (VPOL[d] != 0);
            if (n >= 0) begin
                h = n % HT;
                v = (n / HT) % VT;
                if (h < FBW[d] * SC[d] && v < FBH[d] * SC[d])
                    m_addr[d] = (v / SC[d]) * FBW[d] + h / SC[d];
            end
            chk("addr", d, 32'(addr_o[d]), 32'(m_addr[d]));
            m = n - LAT[d] - 1;
            if (m < 0) begin
                ehs = !hp; evs = !vp; efs = 1'b0; epix = 6'd0;
            end else begin
                h = m % HT;
                v = (m / HT) % VT;
                ehs  = (h >= HA + HF && h < HA + HF + HS) ? hp : !hp;
                evs  = (v >= VA + VF && v < VA + VF + VS) ? vp : !vp;
                efs  = (h == 0 && v == 0);
                epix = 6'd0;
                if (h < HA && v < VA) begin
                    if (h < FBW[d] * SC[d] && v < FBH[d] * SC[d])
                        epix = ram_word(17'((v / SC[d]) * FBW[d] + h / SC[d]), salt);
                    else
                        epix = border;
                end
            end
            chk("hsync", d, 32'(hs_o[d]), 32'(ehs));
            chk("vsync", d, 32'(vs_o[d]), 32'(evs));
            chk("frame_start", d, 32'(fs_o[d]), 32'(efs));
            chk("rgb", d, 32'({r_o[d], g_o[d], b_o[d]}), 32'(epix));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            running = 1'b0;
            n = -1;
            for (int d = 0; d < NDUT; d++) m_addr[d] = 0;
        end else if (running) begin
            n++;
        end else if (fb_ready) begin
            running = 1'b1;
            n = 0;
        end
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        reset    = 1'b1;
        fb_ready = 1'b0;
        border   = 6'b101010;
        salt     = 6'd0;
        for (int d = 0; d < NDUT; d++) m_addr[d] = 0;

        repeat (3) tick();
        reset = 1'b0;
        repeat (50) tick();

        fb_ready = 1'b1;
        tick();
        // fb_ready is ignored once running; toggle it to show that.
        for (int i = 0; i < 2 * HT * VT + 8; i++) begin
            fb_ready = 1'($urandom_range(0, 1));
            tick();
        end
        repeat ($urandom_range(3 * HT, HT * VT - 1)) tick();

        reset    = 1'b1;
        fb_ready = 1'b0;
        tick();
        reset  = 1'b0;
        border = 6'($urandom);
        salt   = 6'($urandom);
        repeat (50) tick();

        fb_ready = 1'b1;
        tick();
        for (int i = 0; i < HT * VT + 2 * HT; i++) begin
            fb_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
